ika9958_vtc: RTL and testbench

- Video timing counter for IKA9958. Sits directly downstream of the reset/clock control block.
- Consumes phiA, the phiA negative clock enable, and the phiL (dot) clock enable. Produces horizontal/vertical dot and line counters, sync, blanking, active-window and field signals.
- The VRAM sequencer, pattern fetch and video output stages consume these outputs.

---
 rtl/ika9958_vtc_pkg.sv | 37 +++
 rtl/ika9958_vtc_win.sv | 30 +++
 rtl/ika9958_vtc.sv | 117 +++++++++++
 tb/tb_ika9958_vtc.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ika9958_vtc_pkg.sv
// rtl/ika9958_vtc_pkg.sv - shared timing constants, mode record and helpers for the video timing counter
package ika9958_vtc_pkg;

  localparam logic [8:0] H_TOTAL        = 9'd342;
  localparam logic [8:0] H_SYNC_W       = 9'd26;
  localparam logic [8:0] V_SYNC_W       = 9'd3;
  localparam logic [8:0] LINES_NTSC     = 9'd262;
  localparam logic [8:0] LINES_NTSC_ODD = 9'd263;
  localparam logic [8:0] LINES_PAL      = 9'd313;
  localparam logic [8:0] LINES_PAL_ODD  = 9'd312;

  localparam logic signed [9:0] H_ACT_BASE = 10'sd59;
  localparam logic signed [9:0] H_ACT_W    = 10'sd256;
  localparam logic signed [9:0] V_ACT_W    = 10'sd192;
  localparam logic signed [9:0] V_ACT_W_LN = 10'sd212;

  // First active line at zero adjust, indexed by {pal, ln}
  localparam logic signed [9:0] V_BASE [4] = '{10'sd27, 10'sd17, 10'sd54, 10'sd44};

  typedef struct packed {
    logic pal;
    logic il;
    logic ln;
  } vtc_mode_t;

  function automatic logic signed [9:0] sext4(input logic [3:0] v);
    return {{6{v[3]}}, v};
  endfunction

  // Odd interlaced field is one line longer on NTSC and one shorter on PAL
  function automatic logic [8:0] frame_lines(input vtc_mode_t m, input logic field);
    if (m.pal)
      return (m.il && field) ? LINES_PAL_ODD : LINES_PAL;
    return (m.il && field) ? LINES_NTSC_ODD : LINES_NTSC;
  endfunction

endpackage

// File: rtl/ika9958_vtc_win.sv
// rtl/ika9958_vtc_win.sv - registered window comparator: flags start <= count < start+length
module ika9958_vtc_win (
  input  logic              i_clk,
  input  logic              i_RST_n,
  input  logic              i_en,
  input  logic signed [9:0] i_cnt,
  input  logic signed [9:0] i_start,
  input  logic signed [9:0] i_len,
  output logic              o_inside
);

  logic signed [9:0] w_end;
  logic              w_in;
  logic              r_inside;

  always_comb begin
    w_end = i_start + i_len;
    w_in  = (i_cnt >= i_start) && (i_cnt < w_end);
  end

  always_ff @(posedge i_clk) begin
    if (!i_RST_n)
      r_inside <= 1'b0;
    else if (i_en)
      r_inside <= w_in;
  end

  assign o_inside = r_inside;

endmodule

// File: rtl/ika9958_vtc.sv
// rtl/ika9958_vtc.sv - dot/line counters with sync, blanking and field generation
module ika9958_vtc
  import ika9958_vtc_pkg::*;
(
  input  logic       i_phiA,
  input  logic       i_RST_n,
  input  logic       i_phiA_NCEN,
  input  logic       i_phiL_PCEN,
  input  logic       i_PAL,
  input  logic       i_IL,
  input  logic       i_LN,
  input  logic [3:0] i_HADJ,
  input  logic [3:0] i_VADJ,
  output logic [8:0] o_HCNT,
  output logic [8:0] o_VCNT,
  output logic       o_FIELD,
  output logic       o_HSYNC_n,
  output logic       o_VSYNC_n,
  output logic       o_HBLANK,
  output logic       o_VBLANK,
  output logic       o_ACTIVE,
  output logic       o_LINE_STRT,
  output logic       o_FRAME_STRT
);

  logic              w_tick, w_hwrap, w_vwrap, w_field_nx, w_hin, w_vin;
  logic [8:0]        r_hcnt, r_vcnt, w_hcnt_nx, w_vcnt_nx;
  logic              r_field, r_hsync_n, r_vsync_n, r_line_strt, r_frame_strt;
  vtc_mode_t         r_mode, w_mode_nx;
  logic [3:0]        r_hadj, r_vadj, w_hadj_nx, w_vadj_nx;
  logic signed [9:0] w_hs, w_vs, w_vlen, w_hcnt_s, w_vcnt_s;

  // Outputs are derived from next-state values so they line up with the counters they describe
  always_comb begin
    w_tick    = i_phiA_NCEN & i_phiL_PCEN;
    w_hwrap   = (r_hcnt == H_TOTAL - 9'd1);
    w_vwrap   = w_hwrap && (r_vcnt == frame_lines(r_mode, r_field) - 9'd1);
    w_hcnt_nx = w_hwrap ? 9'd0 : r_hcnt + 9'd1;
    w_vcnt_nx = r_vcnt;
    if (w_vwrap)
      w_vcnt_nx = 9'd0;
    else if (w_hwrap)
      w_vcnt_nx = r_vcnt + 9'd1;
    w_hadj_nx  = w_hwrap ? i_HADJ : r_hadj;
    w_mode_nx  = r_mode;
    w_vadj_nx  = r_vadj;
    w_field_nx = r_field;
    if (w_vwrap) begin
      w_mode_nx  = '{pal: i_PAL, il: i_IL, ln: i_LN};
      w_vadj_nx  = i_VADJ;
      w_field_nx = i_IL & ~r_field;
    end
    w_hs     = H_ACT_BASE - sext4(w_hadj_nx);
    w_vs     = V_BASE[{w_mode_nx.pal, w_mode_nx.ln}] - sext4(w_vadj_nx);
    w_vlen   = w_mode_nx.ln ? V_ACT_W_LN : V_ACT_W;
    w_hcnt_s = $signed({1'b0, w_hcnt_nx});
    w_vcnt_s = $signed({1'b0, w_vcnt_nx});
  end

  always_ff @(posedge i_phiA) begin
    if (!i_RST_n) begin
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_field      <= 1'b0;
      r_mode       <= '0;
      r_hadj       <= '0;
      r_vadj       <= '0;
      r_hsync_n    <= 1'b0;
      r_vsync_n    <= 1'b0;
      r_line_strt  <= 1'b1;
      r_frame_strt <= 1'b1;
    end else if (w_tick) begin
      r_hcnt       <= w_hcnt_nx;
      r_vcnt       <= w_vcnt_nx;
      r_field      <= w_field_nx;
      r_mode       <= w_mode_nx;
      r_hadj       <= w_hadj_nx;
      r_vadj       <= w_vadj_nx;
      r_hsync_n    <= (w_hcnt_nx >= H_SYNC_W);
      r_vsync_n    <= (w_vcnt_nx >= V_SYNC_W);
      r_line_strt  <= (w_hcnt_nx == 9'd0);
      r_frame_strt <= (w_hcnt_nx == 9'd0) && (w_vcnt_nx == 9'd0);
    end
  end

  ika9958_vtc_win u_hwin (
    .i_clk    (i_phiA),
    .i_RST_n  (i_RST_n),
    .i_en     (w_tick),
    .i_cnt    (w_hcnt_s),
    .i_start  (w_hs),
    .i_len    (H_ACT_W),
    .o_inside (w_hin)
  );

  ika9958_vtc_win u_vwin (
    .i_clk    (i_phiA),
    .i_RST_n  (i_RST_n),
    .i_en     (w_tick),
    .i_cnt    (w_vcnt_s),
    .i_start  (w_vs),
    .i_len    (w_vlen),
    .o_inside (w_vin)
  );

  assign o_HCNT       = r_hcnt;
  assign o_VCNT       = r_vcnt;
  assign o_FIELD      = r_field;
  assign o_HSYNC_n    = r_hsync_n;
  assign o_VSYNC_n    = r_vsync_n;
  assign o_HBLANK     = ~w_hin;
  assign o_VBLANK     = ~w_vin;
  assign o_ACTIVE     = w_hin & w_vin;
  assign o_LINE_STRT  = r_line_strt;
  assign o_FRAME_STRT = r_frame_strt;

endmodule

// File: tb/tb_ika9958_vtc.sv
// tb/tb_ika9958_vtc.sv - self-checking bench for ika9958_vtc against a behavioural timing model
module tb_ika9958_vtc;

  logic       i_phiA = 1'b0;
  logic       i_RST_n = 1'b0;
  logic       i_phiA_NCEN = 1'b1;
  logic       i_phiL_PCEN = 1'b1;
  logic       i_PAL = 1'b0;
  logic       i_IL = 1'b0;
  logic       i_LN = 1'b0;
  logic [3:0] i_HADJ = 4'h0;
  logic [3:0] i_VADJ = 4'h0;
  logic [8:0] o_HCNT, o_VCNT;
  logic       o_FIELD, o_HSYNC_n, o_VSYNC_n, o_HBLANK, o_VBLANK, o_ACTIVE;
  logic       o_LINE_STRT, o_FRAME_STRT;

  ika9958_vtc dut (
    .i_phiA       (i_phiA),
    .i_RST_n      (i_RST_n),
    .i_phiA_NCEN  (i_phiA_NCEN),
    .i_phiL_PCEN  (i_phiL_PCEN),
    .i_PAL        (i_PAL),
    .i_IL         (i_IL),
    .i_LN         (i_LN),
    .i_HADJ       (i_HADJ),
    .i_VADJ       (i_VADJ),
    .o_HCNT       (o_HCNT),
    .o_VCNT       (o_VCNT),
    .o_FIELD      (o_FIELD),
    .o_HSYNC_n    (o_HSYNC_n),
    .o_VSYNC_n    (o_VSYNC_n),
    .o_HBLANK     (o_HBLANK),
    .o_VBLANK     (o_VBLANK),
    .o_ACTIVE     (o_ACTIVE),
    .o_LINE_STRT  (o_LINE_STRT),
    .o_FRAME_STRT (o_FRAME_STRT)
  );

  always #5 i_phiA = ~i_phiA;

  typedef struct {
    logic [3:0] hadj;
    int         first;
    int         last;
  } hvec_t;

  typedef struct {
    bit         pal;
    bit         il;
    bit         ln;
    logic [3:0] vadj;
    int         lines;
    int         field;
    int         vfirst;
    int         vlast;
  } fvec_t;

  int total = 0;
  int bad = 0;
  int en_mode = 0;
  logic [1:0] phase = 2'd0;

  // Reference model state
  int m_h, m_v, m_field, m_pal, m_il, m_ln, m_hadj, m_vadj;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic int frame_len();
    if (m_pal == 0) return (m_il != 0 && m_field != 0) ? 263 : 262;
    return (m_il != 0 && m_field != 0) ? 312 : 313;
  endfunction

  function automatic int vbase();
    if (m_pal == 0) return (m_ln != 0) ? 17 : 27;
    return (m_ln != 0) ? 44 : 54;
  endfunction

  task automatic model_step(input bit rst_n, input bit tick);
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_field = 0; m_pal = 0; m_il = 0; m_ln = 0; m_hadj = 0; m_vadj = 0;
    end else if (tick) begin
      if (m_h == 341) begin
        m_h = 0;
        m_hadj = sx(i_HADJ);
        if (m_v == frame_len() - 1) begin
          m_v = 0;
          m_pal = int'(i_PAL); m_il = int'(i_IL); m_ln = int'(i_LN);
          m_vadj = sx(i_VADJ);
          m_field = (m_il != 0) ? 1 - m_field : 0;
        end else begin
          m_v = m_v + 1;
        end
      end else begin
        m_h = m_h + 1;
      end
    end
  endtask

  task automatic model_check();
    int hs, vs, vlen;
    bit hact, vact;
    hs   = 59 - m_hadj;
    vs   = vbase() - m_vadj;
    vlen = (m_ln != 0) ? 212 : 192;
    hact = (m_h >= hs) && (m_h < hs + 256);
    vact = (m_v >= vs) && (m_v < vs + vlen);
    chk("hcnt", int'(o_HCNT), m_h);
    chk("vcnt", int'(o_VCNT), m_v);
    chk("field", int'(o_FIELD), m_field);
    chk("hsync_n", int'(o_HSYNC_n), int'(m_h >= 26));
    chk("vsync_n", int'(o_VSYNC_n), int'(m_v >= 3));
    chk("hblank", int'(o_HBLANK), int'(!hact));
    chk("vblank", int'(o_VBLANK), int'(!vact));
    chk("active", int'(o_ACTIVE), int'(hact && vact));
    chk("line_strt", int'(o_LINE_STRT), int'(m_h == 0));
    chk("frame_strt", int'(o_FRAME_STRT), int'(m_h == 0 && m_v == 0));
  endtask

  // One phiA cycle: drive enables, advance model at the edge, compare 1 time unit later
  task automatic step();
    case (en_mode)
      0: begin i_phiA_NCEN = 1'b1; i_phiL_PCEN = 1'b1; end
      1: begin i_phiA_NCEN = (phase == 2'd3); i_phiL_PCEN = phase[0]; phase = phase + 2'd1; end
      2: begin i_phiA_NCEN = 1'($urandom_range(0, 1)); i_phiL_PCEN = 1'($urandom_range(0, 1)); end
      default: begin i_phiA_NCEN = 1'b0; i_phiL_PCEN = 1'b1; end
    endcase
    @(posedge i_phiA);
    model_step(i_RST_n, i_phiA_NCEN & i_phiL_PCEN);
    #1;
    model_check();
  endtask

  hvec_t hv [4];
  fvec_t fv [3];

  initial begin
    int n, per, lo, first, last, vmax, vmin_act, vmax_act, fld;
    bit got, prev_ls;

    hv[0] = '{hadj: 4'h0, first: 59, last: 314};
    hv[1] = '{hadj: 4'hF, first: 60, last: 315};
    hv[2] = '{hadj: 4'h7, first: 52, last: 307};
    hv[3] = '{hadj: 4'h8, first: 67, last: 322};

    fv[0] = '{pal: 1'b0, il: 1'b0, ln: 1'b0, vadj: 4'h0, lines: 262, field: 0, vfirst: 27, vlast: 218};
    fv[1] = '{pal: 1'b1, il: 1'b1, ln: 1'b1, vadj: 4'h2, lines: 312, field: 1, vfirst: 42, vlast: 253};
    fv[2] = '{pal: 1'b1, il: 1'b1, ln: 1'b0, vadj: 4'h0, lines: 313, field: 0, vfirst: 54, vlast: 245};

    // Reset held with tick active
    en_mode = 0;
    i_RST_n = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rst_hcnt", int'(o_HCNT), 0);
    chk("rst_vcnt", int'(o_VCNT), 0);
    chk("rst_hsync_n", int'(o_HSYNC_n), 0);
    chk("rst_vsync_n", int'(o_VSYNC_n), 0);
    chk("rst_hblank", int'(o_HBLANK), 1);
    chk("rst_vblank", int'(o_VBLANK), 1);
    chk("rst_active", int'(o_ACTIVE), 0);
    chk("rst_frame_strt", int'(o_FRAME_STRT), 1);
    i_RST_n = 1'b1;
    step();
    chk("first_tick_hcnt", int'(o_HCNT), 1);

    // Random enables, inputs and occasional reset
    en_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      i_RST_n = ($urandom_range(0, 399) != 0);
      i_PAL  = 1'($urandom_range(0, 1));
      i_IL   = 1'($urandom_range(0, 1));
      i_LN   = 1'($urandom_range(0, 1));
      i_HADJ = 4'($urandom_range(0, 15));
      i_VADJ = 4'($urandom_range(0, 15));
      step();
    end

    // Line timing with CM0-style enables, one table row per adjust value
    en_mode = 0;
    i_RST_n = 1'b0;
    step(); step();
    i_RST_n = 1'b1;
    i_HADJ = 4'h0; i_VADJ = 4'h0; i_PAL = 1'b0; i_IL = 1'b0; i_LN = 1'b0;
    en_mode = 1;
    phase = 2'd0;
    prev_ls = o_LINE_STRT;
    for (int r = 0; r < 4; r++) begin
      i_HADJ = hv[r].hadj;
      n = 0; got = 0;
      while (!got && n < 3000) begin
        step(); n++;
        if (o_LINE_STRT && !prev_ls) got = 1;
        prev_ls = o_LINE_STRT;
      end
      chk("line_wait", int'(got), 1);
      per = 0; lo = 0; first = 999; last = -1; got = 0;
      while (!got && per < 3000) begin
        step(); per++;
        if (!o_HSYNC_n) lo++;
        if (!o_HBLANK) begin
          if (int'(o_HCNT) < first) first = int'(o_HCNT);
          if (int'(o_HCNT) > last) last = int'(o_HCNT);
        end
        if (o_LINE_STRT && !prev_ls) got = 1;
        prev_ls = o_LINE_STRT;
      end
      chk("line_period", per, 1368);
      chk("hsync_low", lo, 104);
      chk("hact_first", first, hv[r].first);
      chk("hact_last", last, hv[r].last);
    end

    // Whole frames; next frame's mode is applied mid-frame after random junk
    en_mode = 0;
    i_RST_n = 1'b0;
    i_PAL = 1'b0; i_IL = 1'b0; i_LN = 1'b0; i_VADJ = 4'h0;
    step(); step();
    i_RST_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fld = int'(o_FIELD);
      vmax = -1; vmin_act = 999; vmax_act = -1; n = 0; got = 0;
      while (!got && n < 130000) begin
        if (m_h == 0 && m_v >= 5 && m_v < 90) begin
          i_PAL  = 1'($urandom_range(0, 1));
          i_IL   = 1'($urandom_range(0, 1));
          i_LN   = 1'($urandom_range(0, 1));
          i_VADJ = 4'($urandom_range(0, 15));
        end
        if (m_h == 0 && m_v == 100) begin
          i_PAL = fv[(f < 2) ? f + 1 : 2].pal;
          i_IL  = fv[(f < 2) ? f + 1 : 2].il;
          i_LN  = fv[(f < 2) ? f + 1 : 2].ln;
          i_VADJ = fv[(f < 2) ? f + 1 : 2].vadj;
        end
        if (m_h == 100) i_HADJ = 4'($urandom_range(0, 15));
        step(); n++;
        if (int'(o_VCNT) > vmax) vmax = int'(o_VCNT);
        if (!o_VBLANK) begin
          if (int'(o_VCNT) < vmin_act) vmin_act = int'(o_VCNT);
          if (int'(o_VCNT) > vmax_act) vmax_act = int'(o_VCNT);
        end
        if (o_FRAME_STRT) got = 1;
      end
      chk("frame_end", int'(got), 1);
      chk("frame_lines", vmax + 1, fv[f].lines);
      chk("frame_field", fld, fv[f].field);
      chk("vact_first", vmin_act, fv[f].vfirst);
      chk("vact_last", vmax_act, fv[f].vlast);
    end

    // Mid-frame reset with tick low, then stale latched mode must be gone
    i_HADJ = 4'h0;
    n = 0;
    while (!(m_v == 150 && m_h == 200) && n < 60000) begin step(); n++; end
    chk("reach_v150", int'(m_v == 150 && m_h == 200), 1);
    chk("pre_rst_field", int'(o_FIELD), 1);
    en_mode = 3;
    i_RST_n = 1'b0;
    step();
    chk("midrst_hcnt", int'(o_HCNT), 0);
    chk("midrst_vcnt", int'(o_VCNT), 0);
    chk("midrst_field", int'(o_FIELD), 0);
    i_RST_n = 1'b1;
    step();
    chk("frozen_hcnt", int'(o_HCNT), 0);
    en_mode = 0;
    n = 0;
    while (!(m_v == 27 && m_h == 100) && n < 12000) begin step(); n++; end
    chk("post_rst_vblank", int'(o_VBLANK), 0);
    chk("post_rst_active", int'(o_ACTIVE), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
